// File: rtl/config_cell_dbuf.sv
// config_cell_dbuf
// Double-buffered, multi-lane configuration cell for CGRA PE/switch config chains.
// A SIZE-bit shadow register shifts LANES bits per enabled cycle. The fabric is
// driven from a separate active register that only changes on an accepted
// commit, so a partially shifted word is never visible on config_sig.
// Cells daisy-chain config_out -> config_in; config_en and config_commit are
// broadcast to every cell in the chain.

module config_cell_dbuf #(
   parameter int              SIZE      = 8,
   parameter int              LANES     = 1,
   parameter logic [SIZE-1:0] RESET_VAL = '0
) (
   input  logic             config_clk,
   input  logic             config_reset,
   input  logic             config_en,
   input  logic [LANES-1:0] config_in,
   output logic [LANES-1:0] config_out,
   input  logic             config_commit,
   output logic [SIZE-1:0]  config_sig,
   output logic             config_full,
   output logic             config_ack,
   output logic             config_err
);

   // Number of shifts needed to fill the shadow with one complete word.
   localparam int DEPTH = SIZE / LANES;
   // Counter wide enough to hold 0..DEPTH inclusive.
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] ZERO_C  = CW'(0);

   // A word must split into whole lanes, otherwise the count is meaningless.
   if ((LANES < 1) || ((SIZE % LANES) != 0)) begin : g_bad_geometry
      $error("config_cell_dbuf: SIZE (%0d) must be a multiple of LANES (%0d)", SIZE, LANES);
   end

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_LOADING = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   count_r;
   logic [SIZE-1:0] shadow_r;
   logic [SIZE-1:0] active_r;
   logic            full_r;
   logic            ack_r;
   logic            err_r;

   logic [SIZE-1:0] shadow_nxt_s;
   logic [CW-1:0]   count_inc_s;
   logic            inc_reaches_depth_s;
   state_t          reload_state_s;
   logic            reload_full_s;

   // Next shadow value, count increment and the state used by a back-to-back reload.
   always_comb begin
      shadow_nxt_s        = shadow_r;
      count_inc_s         = count_r;
      inc_reaches_depth_s = 1'b0;
      reload_state_s      = ST_LOADING;
      reload_full_s       = 1'b0;

      // New lane enters at the top; the lowest lane leaves on config_out.
      if (LANES == SIZE) begin
         shadow_nxt_s = config_in[SIZE-1:0];
      end else begin
         shadow_nxt_s = {config_in, shadow_r[SIZE-1:LANES]};
      end

      count_inc_s         = count_r + ONE_C;
      inc_reaches_depth_s = (count_inc_s == DEPTH_C);

      // A single-shift word is already complete after the reload shift.
      if (DEPTH == 1) begin
         reload_state_s = ST_FULL;
         reload_full_s  = 1'b1;
      end else begin
         reload_state_s = ST_LOADING;
         reload_full_s  = 1'b0;
      end
   end

   // Shadow shift register: shifts on every enabled cycle, including pass-through when full.
   always_ff @(posedge config_clk or posedge config_reset) begin
      if (config_reset) begin
         shadow_r <= '0;
      end else if (config_en) begin
         shadow_r <= shadow_nxt_s;
      end else begin
         shadow_r <= shadow_r;
      end
   end

   // Load/commit FSM with its registered status outputs and the active register.
   always_ff @(posedge config_clk or posedge config_reset) begin
      if (config_reset) begin
         state_r  <= ST_EMPTY;
         count_r  <= ZERO_C;
         active_r <= RESET_VAL;
         full_r   <= 1'b0;
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_EMPTY, ST_LOADING: begin
               ack_r <= 1'b0;
               // Committing a partial word is refused and remembered.
               if (config_commit) begin
                  err_r <= 1'b1;
               end else begin
                  err_r <= err_r;
               end
               if (config_en) begin
                  count_r <= count_inc_s;
                  if (inc_reaches_depth_s) begin
                     state_r <= ST_FULL;
                     full_r  <= 1'b1;
                  end else begin
                     state_r <= ST_LOADING;
                     full_r  <= 1'b0;
                  end
               end else begin
                  count_r <= count_r;
                  state_r <= state_r;
                  full_r  <= full_r;
               end
            end

            ST_FULL: begin
               if (config_commit) begin
                  // Active takes the pre-shift shadow even if a shift happens this cycle.
                  active_r <= shadow_r;
                  ack_r    <= 1'b1;
                  err_r    <= err_r;
                  if (config_en) begin
                     // The simultaneous shift is the first lane of the next word.
                     count_r <= ONE_C;
                     state_r <= reload_state_s;
                     full_r  <= reload_full_s;
                  end else begin
                     count_r <= ZERO_C;
                     state_r <= ST_EMPTY;
                     full_r  <= 1'b0;
                  end
               end else begin
                  ack_r   <= 1'b0;
                  count_r <= count_r;
                  state_r <= ST_FULL;
                  full_r  <= 1'b1;
                  // Pass-through shifting overruns this cell's held word.
                  if (config_en) begin
                     err_r <= 1'b1;
                  end else begin
                     err_r <= err_r;
                  end
               end
            end

            default: begin
               // Unreachable encoding: fall back to an empty, error-flagged cell.
               state_r <= ST_EMPTY;
               count_r <= ZERO_C;
               full_r  <= 1'b0;
               ack_r   <= 1'b0;
               err_r   <= 1'b1;
            end
         endcase
      end
   end

   assign config_out  = shadow_r[LANES-1:0];
   assign config_sig  = active_r;
   assign config_full = full_r;
   assign config_ack  = ack_r;
   assign config_err  = err_r;

endmodule

// File: tb/tb_config_cell_dbuf.sv
// tb_config_cell_dbuf
// Scoreboard bench: commits push the expected config_sig into a queue, and a
// negedge monitor pops and compares whenever a cell raises config_ack.
// Three setups share one clock: an 8x2-lane cell (a), an 8x1-lane cell (b)
// and a three-cell 4x1-lane chain (c0 -> c1 -> c2).

module tb_config_cell_dbuf;

   logic clk;
   int   n_cmp;
   int   n_bad;

   // cell a: SIZE=8, LANES=2
   logic       rst_a, en_a, commit_a;
   logic [1:0] in_a, out_a;
   logic [7:0] sig_a;
   logic       full_a, ack_a, err_a;

   // cell b: SIZE=8, LANES=1
   logic       rst_b, en_b, commit_b;
   logic [0:0] in_b, out_b;
   logic [7:0] sig_b;
   logic       full_b, ack_b, err_b;

   // chain c: three cells SIZE=4, LANES=1
   logic       rst_c, en_c, commit_c;
   logic [0:0] in_c, out_c0, out_c1, out_c2;
   logic [3:0] sig_c0, sig_c1, sig_c2;
   logic       full_c0, full_c1, full_c2;
   logic       ack_c0, ack_c1, ack_c2;
   logic       err_c0, err_c1, err_c2;

   logic [7:0]  q_a[$];
   logic [7:0]  q_b[$];
   logic [11:0] q_c[$];
   logic [7:0]  exp_a, exp_b;
   logic [11:0] exp_c;

   config_cell_dbuf #(.SIZE(8), .LANES(2), .RESET_VAL(8'hA5)) dut_a (
      .config_clk(clk), .config_reset(rst_a), .config_en(en_a), .config_in(in_a),
      .config_out(out_a), .config_commit(commit_a), .config_sig(sig_a),
      .config_full(full_a), .config_ack(ack_a), .config_err(err_a));

   config_cell_dbuf #(.SIZE(8), .LANES(1), .RESET_VAL(8'h5A)) dut_b (
      .config_clk(clk), .config_reset(rst_b), .config_en(en_b), .config_in(in_b),
      .config_out(out_b), .config_commit(commit_b), .config_sig(sig_b),
      .config_full(full_b), .config_ack(ack_b), .config_err(err_b));

   config_cell_dbuf #(.SIZE(4), .LANES(1), .RESET_VAL(4'h0)) dut_c0 (
      .config_clk(clk), .config_reset(rst_c), .config_en(en_c), .config_in(in_c),
      .config_out(out_c0), .config_commit(commit_c), .config_sig(sig_c0),
      .config_full(full_c0), .config_ack(ack_c0), .config_err(err_c0));

   config_cell_dbuf #(.SIZE(4), .LANES(1), .RESET_VAL(4'h0)) dut_c1 (
      .config_clk(clk), .config_reset(rst_c), .config_en(en_c), .config_in(out_c0),
      .config_out(out_c1), .config_commit(commit_c), .config_sig(sig_c1),
      .config_full(full_c1), .config_ack(ack_c1), .config_err(err_c1));

   config_cell_dbuf #(.SIZE(4), .LANES(1), .RESET_VAL(4'h0)) dut_c2 (
      .config_clk(clk), .config_reset(rst_c), .config_en(en_c), .config_in(out_c1),
      .config_out(out_c2), .config_commit(commit_c), .config_sig(sig_c2),
      .config_full(full_c2), .config_ack(ack_c2), .config_err(err_c2));

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // monitor: every ack must match the oldest outstanding commit
   always @(negedge clk) begin
      if (ack_a === 1'b1) begin
         if (q_a.size() == 0) begin
            chk("ack_a_unexpected", 32'(ack_a), 32'd0);
         end else begin
            exp_a = q_a.pop_front();
            chk("sig_a_on_ack", 32'(sig_a), 32'(exp_a));
         end
      end
      if (ack_b === 1'b1) begin
         if (q_b.size() == 0) begin
            chk("ack_b_unexpected", 32'(ack_b), 32'd0);
         end else begin
            exp_b = q_b.pop_front();
            chk("sig_b_on_ack", 32'(sig_b), 32'(exp_b));
         end
      end
      if (ack_c0 === 1'b1) begin
         if (q_c.size() == 0) begin
            chk("ack_c_unexpected", 32'(ack_c0), 32'd0);
         end else begin
            exp_c = q_c.pop_front();
            chk("sig_chain_on_ack", 32'({sig_c2, sig_c1, sig_c0}), 32'(exp_c));
            chk("ack_chain_c1", 32'(ack_c1), 32'd1);
            chk("ack_chain_c2", 32'(ack_c2), 32'd1);
         end
      end
   end

   // caller sits at a negedge; one enabled posedge, returns at the next negedge
   task automatic shift_a(input logic [1:0] lane);
      en_a = 1'b1; in_a = lane;
      @(negedge clk);
      en_a = 1'b0; in_a = 2'b00;
   endtask

   task automatic commit_a_exp(input logic [7:0] exp);
      q_a.push_back(exp);
      commit_a = 1'b1;
      @(negedge clk);
      commit_a = 1'b0;
   endtask

   task automatic shift_b(input logic bitv);
      en_b = 1'b1; in_b = bitv;
      @(negedge clk);
      en_b = 1'b0; in_b = 1'b0;
   endtask

   initial begin
      logic [11:0] word;
      n_cmp = 0; n_bad = 0;
      rst_a = 1'b1; en_a = 1'b0; commit_a = 1'b0; in_a = 2'b00;
      rst_b = 1'b1; en_b = 1'b0; commit_b = 1'b0; in_b = 1'b0;
      rst_c = 1'b1; en_c = 1'b0; commit_c = 1'b0; in_c = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // reset state of cell a
      chk("a_rst_sig", 32'(sig_a), 32'h A5);
      chk("a_rst_full", 32'(full_a), 32'd0);
      chk("a_rst_err", 32'(err_a), 32'd0);
      chk("a_rst_out", 32'(out_a), 32'd0);
      chk("a_rst_ack", 32'(ack_a), 32'd0);

      // cell b: reset values, a full serial load, overrun, then mid-cycle async reset
      chk("b_rst_sig", 32'(sig_b), 32'h5A);
      chk("b_rst_full", 32'(full_b), 32'd0);
      for (int i = 0; i < 8; i++) shift_b(1'b1);
      chk("b_full", 32'(full_b), 32'd1);
      chk("b_out_after_load", 32'(out_b), 32'd1);
      q_b.push_back(8'hFF);
      commit_b = 1'b1; @(negedge clk); commit_b = 1'b0;
      chk("b_err_clean_commit", 32'(err_b), 32'd0);
      for (int i = 0; i < 8; i++) shift_b(1'b1);
      shift_b(1'b1);
      chk("b_overrun_err", 32'(err_b), 32'd1);
      chk("b_overrun_full", 32'(full_b), 32'd1);
      #3 rst_b = 1'b1;
      #1;
      chk("b_async_sig", 32'(sig_b), 32'h5A);
      chk("b_async_full", 32'(full_b), 32'd0);
      chk("b_async_err", 32'(err_b), 32'd0);
      chk("b_async_out", 32'(out_b), 32'd0);
      @(negedge clk);
      rst_b = 1'b0;

      // cell a: lanes 01,10,11,00 form 8'h39
      shift_a(2'b01); shift_a(2'b10); shift_a(2'b11);
      chk("a_not_full_3", 32'(full_a), 32'd0);
      shift_a(2'b00);
      chk("a_full_4", 32'(full_a), 32'd1);
      chk("a_out_full", 32'(out_a), 32'b01);
      chk("a_sig_before_commit", 32'(sig_a), 32'hA5);
      commit_a_exp(8'h39);
      chk("a_full_after_commit", 32'(full_a), 32'd0);
      @(negedge clk);
      chk("a_ack_one_cycle", 32'(ack_a), 32'd0);

      // commit with simultaneous shift: active gets old shadow, one lane already counted
      shift_a(2'b11); shift_a(2'b00); shift_a(2'b10); shift_a(2'b01);
      chk("a_full_8h63", 32'(full_a), 32'd1);
      q_a.push_back(8'h63);
      commit_a = 1'b1; en_a = 1'b1; in_a = 2'b10;
      @(negedge clk);
      commit_a = 1'b0; en_a = 1'b0; in_a = 2'b00;
      chk("a_reload_full", 32'(full_a), 32'd0);
      chk("a_reload_err", 32'(err_a), 32'd0);
      shift_a(2'b01); shift_a(2'b11);
      chk("a_reload_not_full_3", 32'(full_a), 32'd0);
      shift_a(2'b00);
      chk("a_reload_full_4", 32'(full_a), 32'd1);
      commit_a_exp(8'h36);

      // premature commit: refused, sticky error
      shift_a(2'b01); shift_a(2'b01); shift_a(2'b01);
      commit_a = 1'b1; @(negedge clk); commit_a = 1'b0;
      chk("a_early_sig", 32'(sig_a), 32'h36);
      chk("a_early_err", 32'(err_a), 32'd1);
      chk("a_early_ack", 32'(ack_a), 32'd0);
      chk("a_early_full", 32'(full_a), 32'd0);
      shift_a(2'b01);
      chk("a_early_then_full", 32'(full_a), 32'd1);
      commit_a_exp(8'h55);
      for (int i = 0; i < 4; i++) shift_a(2'b11);
      commit_a_exp(8'hFF);
      @(negedge clk);
      chk("a_err_sticky", 32'(err_a), 32'd1);
      chk("a_sig_ff", 32'(sig_a), 32'hFF);

      // async reset during the 2nd shift of a load, then a clean reload
      shift_a(2'b11);
      en_a = 1'b1; in_a = 2'b11;
      #2 rst_a = 1'b1;
      #1;
      chk("a_midrst_sig", 32'(sig_a), 32'hA5);
      chk("a_midrst_full", 32'(full_a), 32'd0);
      chk("a_midrst_err", 32'(err_a), 32'd0);
      chk("a_midrst_out", 32'(out_a), 32'd0);
      chk("a_midrst_ack", 32'(ack_a), 32'd0);
      @(negedge clk);
      rst_a = 1'b0; en_a = 1'b0; in_a = 2'b00;
      shift_a(2'b10); shift_a(2'b00); shift_a(2'b01);
      chk("a_post_rst_not_full", 32'(full_a), 32'd0);
      shift_a(2'b11);
      commit_a_exp(8'hD2);
      chk("a_post_rst_err", 32'(err_a), 32'd0);

      // three-cell chain: 12'hABC LSB first, first nibble travels farthest
      word = 12'hABC;
      for (int i = 0; i < 12; i++) begin
         en_c = 1'b1; in_c = word[i];
         @(negedge clk);
      end
      en_c = 1'b0; in_c = 1'b0;
      chk("c_full_c0", 32'(full_c0), 32'd1);
      chk("c_full_c2", 32'(full_c2), 32'd1);
      q_c.push_back(12'hCBA);
      commit_c = 1'b1; @(negedge clk); commit_c = 1'b0;
      chk("c_cell0_A", 32'(sig_c0), 32'hA);

      repeat (3) @(negedge clk);
      chk("q_a_drained", 32'(q_a.size()), 32'd0);
      chk("q_b_drained", 32'(q_b.size()), 32'd0);
      chk("q_c_drained", 32'(q_c.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
